// File: rtl/bm_mac_pkg.sv
// bm_mac_pkg: shared Booth digit codes, width helpers and the sign-extension correction constant
package bm_mac_pkg;

  typedef enum logic [2:0] {ZERO, POS1, NEG1, POS2, NEG2} booth_e;

  function automatic int prod_w(int man_w, int exp_w);
    return 2 * man_w + 2 * ((1 << exp_w) - 1);
  endfunction

  function automatic int booth_digits(int man_w);
    return man_w / 2 + 1;
  endfunction

  // Sum of the negative sign weights of every partial-product row, so rows can carry an inverted sign bit instead of a full sign extension
  function automatic logic [63:0] booth_corr(int man_w);
    logic [63:0] k;
    k = '0;
    for (int i = 0; i < booth_digits(man_w); i++) k = k - (64'd1 << (man_w + 1 + 2 * i));
    return k;
  endfunction

endpackage

// File: rtl/bm_mac_pipe_if.sv
// bm_mac_pipe_if: beat input and result output handshake bundle of the MAC lane
interface bm_mac_pipe_if #(
  parameter int MAN_W = 6,
  parameter int EXP_W = 2,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [MAN_W-1:0] op_a_dat;
  logic [MAN_W-1:0] op_b_dat;
  logic [EXP_W-1:0] op_a_exp;
  logic [EXP_W-1:0] op_b_exp;
  logic [MAN_W-1:0] op_c_dat;
  logic [EXP_W-1:0] op_c_exp;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [LEN_W-1:0] out_cnt;
  logic             out_trunc;
  logic             out_sat;

  modport master (
    output in_valid, in_last, op_a_dat, op_b_dat, op_a_exp, op_b_exp, op_c_dat, op_c_exp, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_trunc, out_sat
  );

  modport slave (
    input  in_valid, in_last, op_a_dat, op_b_dat, op_a_exp, op_b_exp, op_c_dat, op_c_exp, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_trunc, out_sat
  );
endinterface

// File: rtl/bm_booth_sel.sv
// bm_booth_sel: radix-4 Booth digit selector returning the (possibly inverted) multiple of A
module bm_booth_sel
  import bm_mac_pkg::*;
#(
  parameter int MAN_W = 6
) (
  input  logic [2:0]       code_i,
  input  logic [MAN_W-1:0] a_i,
  output logic [MAN_W:0]   sel_o,
  output logic             inv_o
);
  booth_e         dig;
  logic [MAN_W:0] mag;

  // Decode the overlapping 3-bit window and pick 0, A or 2A; negatives are one's complement plus inv_o
  always_comb begin
    dig = (code_i == 3'b001 || code_i == 3'b010) ? POS1 :
          (code_i == 3'b011) ? POS2 :
          (code_i == 3'b100) ? NEG2 :
          (code_i == 3'b101 || code_i == 3'b110) ? NEG1 : ZERO;
    mag = (dig == POS1 || dig == NEG1) ? {1'b0, a_i} :
          (dig == POS2 || dig == NEG2) ? {a_i, 1'b0} : '0;
    inv_o = dig == NEG1 || dig == NEG2;
    sel_o = inv_o ? ~mag : mag;
  end
endmodule

// File: rtl/bm_mac_pipe.sv
// bm_mac_pipe: 3-stage Booth/CSA block-minifloat dot-product MAC; define BM_MAC_SATURATE_EN for saturating accumulation
module bm_mac_pipe
  import bm_mac_pkg::*;
#(
  parameter int MAN_W = 6,
  parameter int EXP_W = 2,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  bm_mac_pipe_if.slave bus
);
  localparam int PW  = prod_w(MAN_W, EXP_W);
  localparam int ND  = booth_digits(MAN_W);
  localparam int RW  = 2 * MAN_W;
  localparam int BW  = 2 * ND;
  localparam int AW1 = ACC_W + 1;
  localparam logic [RW-1:0]    CORR    = RW'(booth_corr(MAN_W));
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic             stall;
  logic             s1_v_q, s1_last_q;
  logic [MAN_W-1:0] s1_a_q, s1_b_q, s1_c_q;
  logic [EXP_W:0]   s1_e_q;
  logic [EXP_W-1:0] s1_ce_q;
  logic             s2_v_q, s2_last_q;
  logic [RW-1:0]    s2_sum_q, s2_car_q;
  logic [MAN_W-1:0] s2_c_q;
  logic [EXP_W:0]   s2_e_q;
  logic [EXP_W-1:0] s2_ce_q;
  logic [ACC_W-1:0] acc_q, out_data_q;
  logic [LEN_W-1:0] cnt_q, out_cnt_q;
  logic             sat_q, out_valid_q, out_trunc_q, out_sat_q;
  logic [BW:0]      b_ext;
  logic [MAN_W:0]   sel [ND];
  logic [ND-1:0]    inv;
  logic [RW-1:0]    sum_d, car_d, row, tmp, prod;
  logic [PW-1:0]    p;
  logic [AW1-1:0]   base, acc_sum;
  logic [ACC_W-1:0] acc_d;
  logic [LEN_W-1:0] cnt_d;
  logic             sat_d, close;

  assign stall         = out_valid_q && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_trunc = out_trunc_q;
  assign bus.out_sat   = out_sat_q;

  // S1: register the accepted beat; exponents are pre-summed here
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1_v_q, s1_last_q, s1_a_q, s1_b_q, s1_c_q, s1_e_q, s1_ce_q} <= '0;
    else if (!stall) begin
      s1_v_q    <= bus.in_valid;
      s1_last_q <= bus.in_last;
      s1_a_q    <= bus.op_a_dat;
      s1_b_q    <= bus.op_b_dat;
      s1_c_q    <= bus.op_c_dat;
      s1_e_q    <= bus.op_a_exp + bus.op_b_exp;
      s1_ce_q   <= bus.op_c_exp;
    end

  // B is zero-extended on top so the highest digit is never negative for an unsigned operand
  assign b_ext = {{(BW - MAN_W){1'b0}}, s1_b_q, 1'b0};

  for (genvar g = 0; g < ND; g++) begin : g_dig
    bm_booth_sel #(.MAN_W(MAN_W)) u_sel (
      .code_i(b_ext[2*g +: 3]),
      .a_i   (s1_a_q),
      .sel_o (sel[g]),
      .inv_o (inv[g])
    );
  end

  // CSA reduction of correction constant, +1 negation bits and all rows, modulo 2^RW where the exact product fits
  always_comb begin
    row = '0;
    tmp = '0;
    sum_d = CORR;
    car_d = '0;
    for (int i = 0; i < ND; i++) car_d[2*i] = inv[i];
    for (int i = 0; i < ND; i++) begin
      row = RW'({~inv[i], sel[i]}) << (2 * i);
      tmp = sum_d ^ car_d ^ row;
      car_d = ((sum_d & car_d) | (sum_d & row) | (car_d & row)) << 1;
      sum_d = tmp;
    end
  end

  // S2: register the redundant sum/carry product with its side information
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s2_v_q, s2_last_q, s2_sum_q, s2_car_q, s2_c_q, s2_e_q, s2_ce_q} <= '0;
    else if (!stall) begin
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_last_q;
      s2_sum_q  <= sum_d;
      s2_car_q  <= car_d;
      s2_c_q    <= s1_c_q;
      s2_e_q    <= s1_e_q;
      s2_ce_q   <= s1_ce_q;
    end

  // Final add, exponent shift, bias on the first beat and overflow policy
  always_comb begin
    prod = s2_sum_q + s2_car_q;
    p = {{(PW - RW){1'b0}}, prod} << s2_e_q;
    base = (cnt_q == '0) ? AW1'(s2_c_q) << s2_ce_q : {1'b0, acc_q};
    acc_sum = base + AW1'(p);
`ifdef BM_MAC_SATURATE_EN
    sat_d = sat_q || acc_sum[ACC_W];
    acc_d = sat_d ? '1 : acc_sum[ACC_W-1:0];
`else
    sat_d = 1'b0;
    acc_d = acc_sum[ACC_W-1:0];
`endif
    cnt_d = cnt_q + 1'b1;
    close = s2_last_q || cnt_d == CNT_MAX;
  end

  // S3: accumulate, close vectors into the result register, and hold the result until accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {acc_q, cnt_q, sat_q} <= '0;
      {out_valid_q, out_data_q, out_cnt_q, out_trunc_q, out_sat_q} <= '0;
    end else begin
      if (!stall && s2_v_q) begin
        acc_q <= close ? '0 : acc_d;
        cnt_q <= close ? '0 : cnt_d;
        sat_q <= close ? 1'b0 : sat_d;
        if (close) begin
          out_data_q  <= acc_d;
          out_cnt_q   <= cnt_d;
          out_trunc_q <= !s2_last_q;
          out_sat_q   <= sat_d;
        end
      end
      out_valid_q <= (!stall && s2_v_q && close) || stall;
    end
endmodule

// File: tb/tb_bm_mac_pipe.sv
// tb_bm_mac_pipe: scoreboard bench for bm_mac_pipe with directed cases and randomized traffic
module tb_bm_mac_pipe;
  localparam int MW = 6;
  localparam int EW = 2;
  localparam int AW = 19;
  localparam int LW = 3;

  typedef struct packed {
    logic [AW-1:0] d;
    logic [LW-1:0] c;
    logic          t;
    logic          s;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bm_mac_pipe_if #(.MAN_W(MW), .EXP_W(EW), .ACC_W(AW), .LEN_W(LW)) bi ();
  bm_mac_pipe #(.MAN_W(MW), .EXP_W(EW), .ACC_W(AW), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));

  int n_chk = 0;
  int n_fail = 0;
  res_t exp_q[$];
  res_t seen[$];
  res_t mon_cur, mon_exp, prev_res;
  bit prev_stall = 0;
  longint unsigned m_acc = 0;
  int m_cnt = 0;
  bit m_sat = 0;
  bit rand_rdy = 0, rdy_force = 1, rnd_rdy = 1;

  assign bi.out_ready = rand_rdy ? rnd_rdy : rdy_force;
  always @(posedge clk) begin #1; rnd_rdy = ($urandom_range(0, 3) != 0); end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Reference: exact integer products, bias on the first beat, close on last or length limit
  function automatic void model_beat();
    longint unsigned lim, pr;
    res_t r;
    lim = (64'd1 << AW) - 1;
    pr = (longint'(bi.op_a_dat) * longint'(bi.op_b_dat)) << (int'(bi.op_a_exp) + int'(bi.op_b_exp));
    if (m_cnt == 0) m_acc = longint'(bi.op_c_dat) << int'(bi.op_c_exp);
    m_acc = m_acc + pr;
    m_cnt++;
    if (m_acc > lim) begin
`ifdef BM_MAC_SATURATE_EN
      m_acc = lim;
      m_sat = 1;
`else
      m_acc = m_acc % (lim + 1);
`endif
    end
    if (bi.in_last || m_cnt == (1 << LW) - 1) begin
      r.d = AW'(m_acc);
      r.c = LW'(m_cnt);
      r.t = !bi.in_last;
      r.s = m_sat;
      exp_q.push_back(r);
      m_acc = 0;
      m_cnt = 0;
      m_sat = 0;
    end
  endfunction

  always @(negedge clk) if (rst_n && bi.in_valid && bi.in_ready) model_beat();

  always @(negedge rst_n) begin
    exp_q.delete();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      mon_cur = {bi.out_data, bi.out_cnt, bi.out_trunc, bi.out_sat};
      chk("in_ready", bi.in_ready, !(bi.out_valid && !bi.out_ready));
      if (prev_stall) begin
        chk("hold_valid", bi.out_valid, 1);
        chk("hold_result", mon_cur, prev_res);
      end
      if (bi.out_valid && bi.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got data %0d, expected no result", bi.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("out_data", bi.out_data, mon_exp.d);
          chk("out_cnt", bi.out_cnt, mon_exp.c);
          chk("out_trunc", bi.out_trunc, mon_exp.t);
          chk("out_sat", bi.out_sat, mon_exp.s);
        end
        seen.push_back(mon_cur);
      end
      prev_stall = bi.out_valid && !bi.out_ready;
      prev_res = mon_cur;
    end
  end

  task automatic beat(input bit v, input bit last, input int a, input int ea, input int b, input int eb, input int c, input int ec);
    int t;
    t = 0;
    bi.in_valid = v;
    bi.in_last = last;
    bi.op_a_dat = MW'(a);
    bi.op_a_exp = EW'(ea);
    bi.op_b_dat = MW'(b);
    bi.op_b_exp = EW'(eb);
    bi.op_c_dat = MW'(c);
    bi.op_c_exp = EW'(ec);
    @(negedge clk);
    while (v && !bi.in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", t);
    end
    @(posedge clk);
    #1;
    bi.in_valid = 0;
  endtask

  task automatic rbeat(input bit last);
    beat(1, last, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 63),
         $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bi.out_valid) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bi.in_valid = 0; bi.in_last = 0;
    bi.op_a_dat = 0; bi.op_b_dat = 0; bi.op_c_dat = 0;
    bi.op_a_exp = 0; bi.op_b_exp = 0; bi.op_c_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bi.out_valid, 0);
    chk("rst_data", bi.out_data, 0);
    chk("rst_cnt", bi.out_cnt, 0);
    chk("rst_trunc", bi.out_trunc, 0);
    chk("rst_sat", bi.out_sat, 0);
    chk("rst_in_ready", bi.in_ready, 1);
    rst_n = 1;
    @(posedge clk);
    #1;

    seen.delete();
    beat(1, 1, 33, 1, 40, 2, 5, 0);
    chk("lat_k", bi.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_k1", bi.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_k2", bi.out_valid, 1);
    chk("single_data", bi.out_data, 10565);
    chk("single_cnt", bi.out_cnt, 1);
    wait_idle();

    seen.delete();
    repeat (2) beat(1, 0, 63, 3, 63, 3, 63, 3);
    beat(1, 1, 63, 3, 63, 3, 63, 3);
    wait_idle();
    chk("ovf_n", seen.size(), 1);
    if (seen.size() > 0) begin
`ifdef BM_MAC_SATURATE_EN
      chk("ovf_data", seen[0].d, 524287);
      chk("ovf_sat", seen[0].s, 1);
`else
      chk("ovf_data", seen[0].d, 238264);
      chk("ovf_sat", seen[0].s, 0);
`endif
    end

    seen.delete();
    repeat (8) beat(1, 0, 1, 0, 1, 0, 0, 0);
    beat(1, 1, 1, 0, 1, 0, 0, 0);
    repeat (6) beat(1, 0, 1, 0, 1, 0, 0, 0);
    beat(1, 1, 1, 0, 1, 0, 0, 0);
    wait_idle();
    chk("lim_n", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("lim_cnt0", seen[0].c, 7);
      chk("lim_trunc0", seen[0].t, 1);
      chk("lim_data0", seen[0].d, 7);
      chk("lim_cnt1", seen[1].c, 2);
      chk("lim_trunc1", seen[1].t, 0);
      chk("lim_cnt2", seen[2].c, 7);
      chk("lim_trunc2", seen[2].t, 0);
    end

    seen.delete();
    rbeat(1);
    t = 0;
    while (!bi.out_valid && t < 20) begin @(posedge clk); #1; t++; end
    rdy_force = 0;
    bi.in_valid = 1;
    bi.in_last = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", bi.in_ready, 0);
      chk("bp_valid", bi.out_valid, 1);
    end
    @(posedge clk); #1;
    rdy_force = 1;
    rbeat(0);
    rbeat(1);
    rbeat(1);
    wait_idle();
    chk("bp_n", seen.size(), 3);

    rdy_force = 0;
    rbeat(1);
    beat(1, 0, 63, 3, 63, 3, 63, 3);
    beat(1, 0, 63, 3, 63, 3, 63, 3);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", bi.out_valid, 0);
    chk("mid_rst_data", bi.out_data, 0);
    chk("mid_rst_cnt", bi.out_cnt, 0);
    chk("mid_rst_in_ready", bi.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rdy_force = 1;
    rst_n = 1;
    seen.delete();
    @(posedge clk); #1;
    beat(1, 0, 1, 0, 2, 0, 3, 0);
    beat(1, 0, 1, 0, 2, 0, 3, 0);
    beat(1, 0, 1, 0, 2, 0, 3, 0);
    beat(1, 1, 1, 0, 2, 0, 3, 0);
    wait_idle();
    chk("post_rst_n", seen.size(), 1);
    if (seen.size() == 1) begin
      chk("post_rst_cnt", seen[0].c, 4);
      chk("post_rst_data", seen[0].d, 11);
    end

    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) beat(0, 0, 0, 0, 0, 0, 0, 0);
      else rbeat($urandom_range(0, 3) == 0);
    end
    rand_rdy = 0;
    rbeat(1);
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bm_mac_pipe.md
# bm_mac_pipe

Parametrised, pipelined block-minifloat multiply-accumulate engine. Successor to the fixed 6x6 MBE multiplier: generic mantissa/exponent widths, valid/ready handshake with backpressure, and multi-beat dot-product accumulation with per-vector bias. Sits between operand fetch and result writeback in the BM MAC array, one instance per lane.

## Interface
- `MAN_W`, default 6: unsigned fraction width, including the implicit bit.
- `EXP_W`, default 2: unsigned exponent width.
- `ACC_W`, default 32: accumulator width. Must satisfy ACC_W >= 2*MAN_W + 2*(2^EXP_W-1) + 1.
- `LEN_W`, default 8: beat-counter width. Maximum vector length is 2^LEN_W-1.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. Beat valid.
- `in_ready`: output, 1 bit. Beat accepted when in_valid && in_ready at the clock edge.
- `in_last`: input, 1 bit. Final beat of the vector.
- `op_a_dat`, `op_b_dat`: input, MAN_W bits. Unsigned fractions.
- `op_a_exp`, `op_b_exp`: input, EXP_W bits. Exponent shifts.
- `op_c_dat`: input, MAN_W bits. Bias fraction; sampled only on the first beat of a vector.
- `op_c_exp`: input, EXP_W bits. Bias exponent; sampled only on the first beat of a vector.
- `out_valid`: output, 1 bit. Result valid; held until out_ready.
- `out_ready`: input, 1 bit. Downstream accept.
- `out_data`: output, ACC_W bits. Accumulated result.
- `out_cnt`: output, LEN_W bits. Number of beats in the vector.
- `out_trunc`: output, 1 bit. Vector was force-closed at the counter limit.
- `out_sat`: output, 1 bit. Accumulator saturated (saturation build only).

## Operation
- Per beat, the product is P = (op_a_dat * op_b_dat) << (op_a_exp + op_b_exp), computed exactly and unsigned.
  - P is formed by radix-4 modified Booth recoding of op_b_dat: floor(MAN_W/2)+1 digits, each selecting {0, ±A, ±2A}.
  - Sign-extension is removed with a constant correction term.
  - Partial products are reduced by a CSA tree to sum/carry.
- First beat of a vector (beat counter = 0): acc = P + (op_c_dat << op_c_exp).
- Subsequent beats: acc = acc + P.
- Vector close: on in_last, or when the beat count reaches 2^LEN_W-1 without in_last.
  - On forced close, out_trunc = 1. The next beat starts a new vector.
  - The result register captures acc, the count and the flags. out_valid is set, acc clears and the counter clears.
- Overflow handling without the macro: acc wraps modulo 2^ACC_W.
- Beats with in_valid low are bubbles: no accumulation, counter unchanged.

## Timing
- Pipeline stages:
  - S1: operand registers.
  - S2: Booth/CSA sum/carry registers.
  - S3: final add, accumulator and output registers.
- Latency: a last beat accepted at edge k produces out_valid = 1 after edge k+2.
- Throughput: one beat per clock when not stalled.
- Stall condition: stall = out_valid && !out_ready.
  - While stalled, all stages hold and in_ready = 0.
  - Otherwise in_ready = 1.
  - in_ready is combinational from out_valid and out_ready only.
- out_valid clears on the edge where out_ready = 1, unless a new result is captured on that same edge; in that case out_valid stays 1 with the new data.
- A result is never overwritten while out_valid && !out_ready.
- Reset (asynchronous, any time, including mid-vector):
  - All stage valids, acc and the counter go to 0. The partial vector is discarded.
  - Output reset values: out_valid = 0, out_data = 0, out_cnt = 0, out_trunc = 0, out_sat = 0.
  - in_ready = 1 after reset.
- in_last and counter-limit on the same beat: closes normally, out_trunc = 0.

## Configuration
- Macro: `BM_MAC_SATURATE_EN`.
- Defined:
  - Any accumulate whose true sum exceeds 2^ACC_W-1 clamps acc to all-ones.
  - A sticky saturation flag is set for the vector and reported in out_sat with the result.
  - Further beats in the same vector leave acc at all-ones.
- Undefined: wrap-around arithmetic, and out_sat is tied to 0.

## Structure
- Package `bm_mac_pkg` holds:
  - Booth code enum: ZERO, POS1, NEG1, POS2, NEG2.
  - Width functions: product width 2*MAN_W + 2*(2^EXP_W-1), and digit count.
  - The correction-constant function.
- Sub-module `bm_booth_sel`, parametrised by MAN_W: takes a 3-bit code and A, and returns a MAN_W+1-bit selected digit plus an inversion bit. Instantiated per digit with a generate loop.
- Pipeline control (stall, valids) stays in the top module.

## Test plan
- Single beat, defaults:
  - Inputs: a=33, exp 1; b=40, exp 2; c=5, exp 0; in_last=1.
  - Expected: out_data=10565, out_cnt=1, out_valid 2 edges after acceptance.
- 4-beat vector:
  - Inputs: a=63, b=63, exps 3/3 each beat; c=63, exp 3.
  - Expected: out_data = 4*254016 + 504 = 1016568, out_cnt=4.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with continuous in_valid.
  - Expected: in_ready=0 throughout, result stable. Release, and the next vector's result follows with no beat lost or duplicated.
- Counter limit, LEN_W=2:
  - Stimulus: 5 beats with no in_last.
  - Expected: first result out_cnt=3, out_trunc=1. The 4th and 5th beats form a new vector.
- Saturation, ACC_W=19, macro on:
  - Stimulus: 3 max beats.
  - Expected: out_data=524287, out_sat=1. Macro off: out_data = (3*254016 + bias) mod 2^19, out_sat=0.
- Reset mid-vector:
  - Stimulus: assert rst_n=0 after beat 2 of 4.
  - Expected: outputs 0 immediately. The next vector's result excludes the pre-reset beats.
